// File: rtl/multicycle_controller_pkg.sv
// ============================================================================
// Module      : multicycle_controller_pkg
// Description : State encodings, opcode constants and datapath select codes
//               shared by the RV32I multi-cycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_controller_pkg;

    localparam int unsigned c_STATE_W = 4;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_RESET  = 4'd0;
    localparam state_t c_ST_FETCH  = 4'd1;
    localparam state_t c_ST_DECODE = 4'd2;
    localparam state_t c_ST_EXEC_R = 4'd3;
    localparam state_t c_ST_EXEC_I = 4'd4;
    localparam state_t c_ST_ALU_WB = 4'd5;
    localparam state_t c_ST_ADDR   = 4'd6;
    localparam state_t c_ST_MEM_RD = 4'd7;
    localparam state_t c_ST_MEM_WB = 4'd8;
    localparam state_t c_ST_MEM_WR = 4'd9;
    localparam state_t c_ST_BRANCH = 4'd10;
    localparam state_t c_ST_JAL    = 4'd11;
    localparam state_t c_ST_HALT   = 4'd12;

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    localparam logic [2:0] c_F3_BEQ = 3'b000;
    localparam logic [2:0] c_F3_BNE = 3'b001;

    localparam logic [1:0] c_ALUOP_ADD = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB = 2'b01;
    localparam logic [1:0] c_ALUOP_R   = 2'b10;
    localparam logic [1:0] c_ALUOP_I   = 2'b11;

    localparam logic [1:0] c_SRCA_PC    = 2'b00;
    localparam logic [1:0] c_SRCA_OLDPC = 2'b01;
    localparam logic [1:0] c_SRCA_RS1   = 2'b10;

    localparam logic [1:0] c_SRCB_RS2  = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR = 2'b01;
    localparam logic [1:0] c_SRCB_IMM  = 2'b10;

    localparam logic [1:0] c_M2R_ALU = 2'b00;
    localparam logic [1:0] c_M2R_MEM = 2'b01;
    localparam logic [1:0] c_M2R_PC  = 2'b10;

    // States that hold a memory request open and are policed by the wait timer
    function automatic logic is_wait_state(input state_t st);
        return (st == c_ST_FETCH) || (st == c_ST_MEM_RD) || (st == c_ST_MEM_WR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_mem_wait_timer.sv
// ============================================================================
// Module      : mem_wait_timer
// Description : Counts wait cycles of an outstanding memory request and flags
//               a timeout when the budget is used up without ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_timer #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_ready,
    output logic o_timeout
);

    localparam logic [7:0] c_MAX = 8'(MEM_WAIT_MAX);

    logic [7:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_enable && !i_ready && (r_count != c_MAX)) begin
            r_count <= r_count + 8'd1;
        end
    end

    // Ready on the last allowed cycle still completes the access
    assign o_timeout = i_enable && !i_ready && (r_count == c_MAX);

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module      : multicycle_controller
// Description : Multi-cycle sequencing FSM for the RV32I datapath; drives mux
//               selects and enables, polices memory waits, counts retirements.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned INSTRET_W    = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [6:0]           i_OPCode,
    input  logic [2:0]           i_Funct3,
    input  logic                 i_Zero,
    input  logic                 i_IMReady,
    input  logic                 i_DMReady,
    output logic                 o_IMReq,
    output logic                 o_IRWrite,
    output logic                 o_PCWrite,
    output logic                 o_PCSrc,
    output logic [1:0]           o_ALUSrcA,
    output logic [1:0]           o_ALUSrcB,
    output logic [1:0]           o_ALUOp,
    output logic                 o_MemRead,
    output logic                 o_MemWrite,
    output logic                 o_RegWrite,
    output logic [1:0]           o_MemToReg,
    output logic                 o_Illegal,
    output logic                 o_BusError,
    output logic                 o_Halted,
    output logic [INSTRET_W-1:0] o_InstRet
);

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_illegal;
    logic                   r_bus_error;
    logic [INSTRET_W-1:0]   r_instret;

    logic                   w_set_illegal;
    logic                   w_ready;
    logic                   w_timeout;
    logic                   w_retire;
    logic                   w_branch_ok;
    logic                   w_branch_taken;

    assign w_ready = (r_state == c_ST_FETCH) ? i_IMReady : i_DMReady;

    // Any state change restarts the count, so each wait state starts fresh
    mem_wait_timer #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_mem_wait_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_next_state != r_state),
        .i_enable  (is_wait_state(r_state)),
        .i_ready   (w_ready),
        .o_timeout (w_timeout)
    );

    assign w_branch_ok    = (i_Funct3 == c_F3_BEQ) || (i_Funct3 == c_F3_BNE);
    assign w_branch_taken = ((i_Funct3 == c_F3_BEQ) &&  i_Zero) ||
                            ((i_Funct3 == c_F3_BNE) && !i_Zero);

    assign w_retire = (w_next_state == c_ST_FETCH) &&
                      (r_state != c_ST_FETCH) && (r_state != c_ST_RESET);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= c_ST_RESET;
            r_illegal   <= 1'b0;
            r_bus_error <= 1'b0;
            r_instret   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_timeout) begin
                r_bus_error <= 1'b1;
            end
            if (w_retire) begin
                r_instret <= r_instret + INSTRET_W'(1);
            end
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_set_illegal = 1'b0;
        case (r_state)
            c_ST_RESET:  w_next_state = c_ST_FETCH;
            c_ST_FETCH: begin
                if (w_timeout) begin
                    w_next_state = c_ST_HALT;
                end else if (i_IMReady) begin
                    w_next_state = c_ST_DECODE;
                end
            end
            c_ST_DECODE: begin
                case (i_OPCode)
                    c_OP_R:                 w_next_state = c_ST_EXEC_R;
                    c_OP_I:                 w_next_state = c_ST_EXEC_I;
                    c_OP_LOAD, c_OP_STORE:  w_next_state = c_ST_ADDR;
                    c_OP_BRANCH:            w_next_state = c_ST_BRANCH;
                    c_OP_JAL:               w_next_state = c_ST_JAL;
                    default: begin
                        w_next_state  = c_ST_HALT;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            c_ST_EXEC_R, c_ST_EXEC_I: w_next_state = c_ST_ALU_WB;
            c_ST_ALU_WB: w_next_state = c_ST_FETCH;
            c_ST_ADDR: begin
                w_next_state = (i_OPCode == c_OP_LOAD) ? c_ST_MEM_RD : c_ST_MEM_WR;
            end
            c_ST_MEM_RD: begin
                if (w_timeout) begin
                    w_next_state = c_ST_HALT;
                end else if (i_DMReady) begin
                    w_next_state = c_ST_MEM_WB;
                end
            end
            c_ST_MEM_WB: w_next_state = c_ST_FETCH;
            c_ST_MEM_WR: begin
                if (w_timeout) begin
                    w_next_state = c_ST_HALT;
                end else if (i_DMReady) begin
                    w_next_state = c_ST_FETCH;
                end
            end
            c_ST_BRANCH: begin
                if (w_branch_ok) begin
                    w_next_state = c_ST_FETCH;
                end else begin
                    w_next_state  = c_ST_HALT;
                    w_set_illegal = 1'b1;
                end
            end
            c_ST_JAL:  w_next_state = c_ST_FETCH;
            c_ST_HALT: w_next_state = c_ST_HALT;
            default:   w_next_state = c_ST_HALT;
        endcase
    end

    always_comb begin
        o_IMReq    = 1'b0;
        o_IRWrite  = 1'b0;
        o_PCWrite  = 1'b0;
        o_PCSrc    = 1'b0;
        o_ALUSrcA  = c_SRCA_PC;
        o_ALUSrcB  = c_SRCB_RS2;
        o_ALUOp    = c_ALUOP_ADD;
        o_MemRead  = 1'b0;
        o_MemWrite = 1'b0;
        o_RegWrite = 1'b0;
        o_MemToReg = c_M2R_ALU;
        case (r_state)
            c_ST_FETCH: begin
                o_IMReq   = 1'b1;
                o_ALUSrcA = c_SRCA_PC;
                o_ALUSrcB = c_SRCB_FOUR;
                o_ALUOp   = c_ALUOP_ADD;
                o_IRWrite = i_IMReady;
                o_PCWrite = i_IMReady;
            end
            c_ST_DECODE: begin
                o_ALUSrcA = c_SRCA_OLDPC;
                o_ALUSrcB = c_SRCB_IMM;
                o_ALUOp   = c_ALUOP_ADD;
            end
            c_ST_EXEC_R: begin
                o_ALUSrcA = c_SRCA_RS1;
                o_ALUSrcB = c_SRCB_RS2;
                o_ALUOp   = c_ALUOP_R;
            end
            c_ST_EXEC_I: begin
                o_ALUSrcA = c_SRCA_RS1;
                o_ALUSrcB = c_SRCB_IMM;
                o_ALUOp   = c_ALUOP_I;
            end
            c_ST_ALU_WB: begin
                o_RegWrite = 1'b1;
                o_MemToReg = c_M2R_ALU;
            end
            c_ST_ADDR: begin
                o_ALUSrcA = c_SRCA_RS1;
                o_ALUSrcB = c_SRCB_IMM;
                o_ALUOp   = c_ALUOP_ADD;
            end
            // Enables are withheld on the cycle the request times out
            c_ST_MEM_RD: o_MemRead  = !w_timeout;
            c_ST_MEM_WB: begin
                o_RegWrite = 1'b1;
                o_MemToReg = c_M2R_MEM;
            end
            c_ST_MEM_WR: o_MemWrite = !w_timeout;
            c_ST_BRANCH: begin
                o_ALUSrcA = c_SRCA_RS1;
                o_ALUSrcB = c_SRCB_RS2;
                o_ALUOp   = c_ALUOP_SUB;
                o_PCSrc   = 1'b1;
                o_PCWrite = w_branch_taken;
            end
            c_ST_JAL: begin
                o_RegWrite = 1'b1;
                o_MemToReg = c_M2R_PC;
                o_PCWrite  = 1'b1;
                o_PCSrc    = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_Illegal  = r_illegal;
    assign o_BusError = r_bus_error;
    assign o_Halted   = (r_state == c_ST_HALT);
    assign o_InstRet  = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Directed self-checking bench for multicycle_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        zero;
    logic        imready;
    logic        dmready;
    logic        imreq, irwrite, pcwrite, pcsrc;
    logic [1:0]  srca, srcb, aluop, memtoreg;
    logic        memread, memwrite, regwrite;
    logic        illegal, buserror, halted;
    logic [31:0] instret;

    int n_total = 0;
    int n_bad   = 0;

    multicycle_controller #(
        .MEM_WAIT_MAX (15),
        .INSTRET_W    (32)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_OPCode   (opcode),
        .i_Funct3   (funct3),
        .i_Zero     (zero),
        .i_IMReady  (imready),
        .i_DMReady  (dmready),
        .o_IMReq    (imreq),
        .o_IRWrite  (irwrite),
        .o_PCWrite  (pcwrite),
        .o_PCSrc    (pcsrc),
        .o_ALUSrcA  (srca),
        .o_ALUSrcB  (srcb),
        .o_ALUOp    (aluop),
        .o_MemRead  (memread),
        .o_MemWrite (memwrite),
        .o_RegWrite (regwrite),
        .o_MemToReg (memtoreg),
        .o_Illegal  (illegal),
        .o_BusError (buserror),
        .o_Halted   (halted),
        .o_InstRet  (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] ctl;
    assign ctl = {imreq, irwrite, pcwrite, pcsrc, srca, srcb, aluop,
                  memread, memwrite, regwrite, memtoreg, illegal, buserror, halted};

    function automatic logic [17:0] mk(input logic rq, irw, pcw, pcs,
                                       input logic [1:0] sa, sb, aop,
                                       input logic mr, mw, rw,
                                       input logic [1:0] m2r,
                                       input logic ill, be, hl);
        return {rq, irw, pcw, pcs, sa, sb, aop, mr, mw, rw, m2r, ill, be, hl};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, check outputs 1ns later
    task automatic cyc(input logic [6:0] op, input logic [2:0] f3, input logic z,
                       input logic imr, input logic dmr,
                       input string tag, input logic [17:0] exp);
        @(negedge clk);
        opcode  = op;
        funct3  = f3;
        zero    = z;
        imready = imr;
        dmready = dmr;
        #1;
        chk(tag, {14'd0, ctl}, {14'd0, exp});
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_ctl", {14'd0, ctl}, 32'd0);
        chk("reset_instret", instret, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam logic [6:0] OP_X  = 7'h7F;

    logic [17:0] e_fetch, e_fetch_w, e_decode, e_exec_r, e_exec_i, e_alu_wb;
    logic [17:0] e_addr, e_mem_rd, e_mem_wb, e_mem_wr, e_br_t, e_br_n, e_jal;
    logic [17:0] e_halt_ill, e_halt_be;

    initial begin
        e_fetch    = mk(1,1,1,0, 2'b00,2'b01,2'b00, 0,0,0, 2'b00, 0,0,0);
        e_fetch_w  = mk(1,0,0,0, 2'b00,2'b01,2'b00, 0,0,0, 2'b00, 0,0,0);
        e_decode   = mk(0,0,0,0, 2'b01,2'b10,2'b00, 0,0,0, 2'b00, 0,0,0);
        e_exec_r   = mk(0,0,0,0, 2'b10,2'b00,2'b10, 0,0,0, 2'b00, 0,0,0);
        e_exec_i   = mk(0,0,0,0, 2'b10,2'b10,2'b11, 0,0,0, 2'b00, 0,0,0);
        e_alu_wb   = mk(0,0,0,0, 2'b00,2'b00,2'b00, 0,0,1, 2'b00, 0,0,0);
        e_addr     = mk(0,0,0,0, 2'b10,2'b10,2'b00, 0,0,0, 2'b00, 0,0,0);
        e_mem_rd   = mk(0,0,0,0, 2'b00,2'b00,2'b00, 1,0,0, 2'b00, 0,0,0);
        e_mem_wb   = mk(0,0,0,0, 2'b00,2'b00,2'b00, 0,0,1, 2'b01, 0,0,0);
        e_mem_wr   = mk(0,0,0,0, 2'b00,2'b00,2'b00, 0,1,0, 2'b00, 0,0,0);
        e_br_t     = mk(0,0,1,1, 2'b10,2'b00,2'b01, 0,0,0, 2'b00, 0,0,0);
        e_br_n     = mk(0,0,0,1, 2'b10,2'b00,2'b01, 0,0,0, 2'b00, 0,0,0);
        e_jal      = mk(0,0,1,1, 2'b00,2'b00,2'b00, 0,0,1, 2'b10, 0,0,0);
        e_halt_ill = mk(0,0,0,0, 2'b00,2'b00,2'b00, 0,0,0, 2'b00, 1,0,1);
        e_halt_be  = mk(0,0,0,0, 2'b00,2'b00,2'b00, 0,0,0, 2'b00, 0,1,1);

        rst_n = 1'b0; opcode = OP_R; funct3 = 3'd0; zero = 1'b0;
        imready = 1'b1; dmready = 1'b1;
        do_reset();

        // ADD x3,x1,x2
        cyc(OP_R, 3'd0, 0, 1, 1, "add_fetch",  e_fetch);
        cyc(OP_R, 3'd0, 0, 1, 1, "add_decode", e_decode);
        cyc(OP_R, 3'd0, 0, 1, 1, "add_exec",   e_exec_r);
        cyc(OP_R, 3'd0, 0, 1, 1, "add_wb",     e_alu_wb);

        // LW with three data-memory wait cycles: 8 cycles total
        cyc(OP_LW, 3'd2, 0, 1, 1, "lw_fetch",  e_fetch);
        chk("instret_add", instret, 32'd1);
        cyc(OP_LW, 3'd2, 0, 1, 1, "lw_decode", e_decode);
        cyc(OP_LW, 3'd2, 0, 1, 1, "lw_addr",   e_addr);
        for (int i = 0; i < 3; i++) begin
            cyc(OP_LW, 3'd2, 0, 1, 0, "lw_mem_wait", e_mem_rd);
        end
        cyc(OP_LW, 3'd2, 0, 1, 1, "lw_mem_rdy", e_mem_rd);
        cyc(OP_LW, 3'd2, 0, 1, 1, "lw_wb",      e_mem_wb);

        // BEQ taken, then BNE with Zero=1 not taken
        cyc(OP_BR, 3'b000, 1, 1, 1, "beq_fetch",  e_fetch);
        chk("instret_lw", instret, 32'd2);
        cyc(OP_BR, 3'b000, 1, 1, 1, "beq_decode", e_decode);
        cyc(OP_BR, 3'b000, 1, 1, 1, "beq_exec",   e_br_t);
        cyc(OP_BR, 3'b001, 1, 1, 1, "bne_fetch",  e_fetch);
        cyc(OP_BR, 3'b001, 1, 1, 1, "bne_decode", e_decode);
        cyc(OP_BR, 3'b001, 1, 1, 1, "bne_exec",   e_br_n);

        // SW zero-wait, ADDI, JAL
        cyc(OP_SW, 3'd2, 0, 1, 1, "sw_fetch",  e_fetch);
        chk("instret_br", instret, 32'd4);
        cyc(OP_SW, 3'd2, 0, 1, 1, "sw_decode", e_decode);
        cyc(OP_SW, 3'd2, 0, 1, 1, "sw_addr",   e_addr);
        cyc(OP_SW, 3'd2, 0, 1, 1, "sw_mem",    e_mem_wr);
        cyc(OP_I,  3'd0, 0, 1, 1, "addi_fetch",  e_fetch);
        chk("instret_sw", instret, 32'd5);
        cyc(OP_I,  3'd0, 0, 1, 1, "addi_decode", e_decode);
        cyc(OP_I,  3'd0, 0, 1, 1, "addi_exec",   e_exec_i);
        cyc(OP_I,  3'd0, 0, 1, 1, "addi_wb",     e_alu_wb);
        cyc(OP_J,  3'd0, 0, 1, 1, "jal_fetch",   e_fetch);
        cyc(OP_J,  3'd0, 0, 1, 1, "jal_decode",  e_decode);
        cyc(OP_J,  3'd0, 0, 1, 1, "jal_exec",    e_jal);

        // IMReady arrives on the last allowed wait cycle, then an illegal opcode
        for (int i = 0; i < 15; i++) begin
            cyc(OP_X, 3'd0, 0, 0, 1, "fetch_wait", e_fetch_w);
        end
        chk("instret_jal", instret, 32'd7);
        cyc(OP_X, 3'd0, 0, 1, 1, "fetch_last_rdy", e_fetch);
        cyc(OP_X, 3'd0, 0, 1, 1, "ill_decode",     e_decode);
        for (int i = 0; i < 3; i++) begin
            cyc(OP_R, 3'd0, 0, 1, 1, "ill_halt", e_halt_ill);
        end
        chk("instret_ill", instret, 32'd7);

        // IMReady stuck low: bus error after MEM_WAIT_MAX+1 fetch cycles
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(OP_R, 3'd0, 0, 0, 1, "to_fetch", e_fetch_w);
        end
        cyc(OP_R, 3'd0, 0, 1, 1, "to_halt", e_halt_be);
        cyc(OP_R, 3'd0, 0, 1, 1, "to_halt_stay", e_halt_be);
        chk("instret_to", instret, 32'd0);

        // Reset asserted in the middle of a stalled store
        do_reset();
        cyc(OP_R,  3'd0, 0, 1, 1, "rs_add_fetch",  e_fetch);
        cyc(OP_R,  3'd0, 0, 1, 1, "rs_add_decode", e_decode);
        cyc(OP_R,  3'd0, 0, 1, 1, "rs_add_exec",   e_exec_r);
        cyc(OP_R,  3'd0, 0, 1, 1, "rs_add_wb",     e_alu_wb);
        cyc(OP_SW, 3'd2, 0, 1, 0, "rs_sw_fetch",   e_fetch);
        cyc(OP_SW, 3'd2, 0, 1, 0, "rs_sw_decode",  e_decode);
        cyc(OP_SW, 3'd2, 0, 1, 0, "rs_sw_addr",    e_addr);
        cyc(OP_SW, 3'd2, 0, 1, 0, "rs_sw_wait",    e_mem_wr);
        cyc(OP_SW, 3'd2, 0, 1, 0, "rs_sw_wait2",   e_mem_wr);
        chk("rs_instret_pre", instret, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rs_memwrite_drop", {31'd0, memwrite}, 32'd0);
        chk("rs_ctl", {14'd0, ctl}, 32'd0);
        chk("rs_instret", instret, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(OP_R, 3'd0, 0, 1, 1, "rs_restart_fetch", e_fetch);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
